connect_four_move_ctrl: RTL and testbench
=========================================

# connect_four_move_ctrl

Sequencer that sits between the player-input logic and the board storage block. It accepts one column-drop request at a time and finds the landing row by scanning the column. It writes the current player's piece, then walks the four line directions through the cell with the player's colour to detect a win. It also tracks the player to move, draw (full board) and game-over status.

## Interface
Parameters:
- ROWS, 8, board rows; row 0 is the bottom.
- COLS, 8, board columns.
- WIN_LEN, 4, pieces in a line needed to win.
- CLEAR_CYCLES, 64, cycles the board block needs to self-clear after reset release.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- move_valid  in  1  player requests a drop.
- move_col  in  3  requested column; must be stable while move_valid=1.
- move_ready  out  1  request is accepted when move_valid & move_ready.
- move_rejected  out  1  one-cycle pulse: the column is full, or the game is over.
- brd_enable  out  1  board read/write enable.
- brd_row  out  3  board row address.
- brd_col  out  3  board column address.
- brd_data_in  out  2  piece to write: 01 for player 1, 10 for player 2.
- brd_write  out  1  write strobe.
- brd_drop_allowed  in  1  the column at brd_col still has space.
- brd_data_out  in  2  combinational read data at brd_row/brd_col.
- current_player  out  2  piece code of the player to move.
- game_over  out  1  set on a win or a draw; sticky until reset.
- winner  out  2  00 for none or draw, otherwise the winner's piece code.

## Operation
States:
- INIT
  - Counts CLEAR_CYCLES cycles with brd_enable=0 and move_ready=0, then goes to IDLE.
- IDLE
  - move_ready = !game_over.
  - brd_col = move_col combinationally, brd_enable=1 for reads.
  - move_valid=1 and game_over=1: pulse move_rejected, stay in IDLE.
  - move_valid=1 and brd_drop_allowed=0: pulse move_rejected, stay in IDLE.
  - Otherwise: latch col, r=0, go to SCAN.
- SCAN
  - Read (r, col) each cycle.
  - brd_data_out==00: latch row=r, go to WRITE.
  - Otherwise r++.
  - r reaching ROWS without finding an empty cell: pulse move_rejected and go to IDLE. This is a defensive path only, for a stale drop_allowed.
- WRITE
  - One cycle: brd_write=1, brd_data_in=current_player at (row, col).
  - Increment the 7-bit piece count.
  - Init dir=0, sign=+, k=1, run=0; go to CHECK.
- CHECK
  - Directions are checked in order: dir0 horizontal (0,+1), dir1 vertical (+1,0), dir2 diagonal (+1,+1), dir3 anti-diagonal (+1,-1).
  - Each cycle probes cell (row + s·k·dr, col + s·k·dc), using signed 5-bit arithmetic.
  - In bounds and equal to current_player: run++, k++.
  - When the cell is out of bounds, mismatched, or k would exceed WIN_LEN-1: if sign=+, switch to sign=- with k=1; if sign=-, evaluate the direction.
  - Evaluation: run ≥ WIN_LEN-1 is a win. Otherwise reset run and move to the next dir.
  - All four directions done with no win: go to FINISH.
  - Out-of-bounds probes are not issued to the board: brd_enable=0 that cycle.
- FINISH
  - One cycle.
  - Win: game_over=1, winner=current_player.
  - No win and count==ROWS·COLS: game_over=1, winner=00.
  - Otherwise toggle current_player (01↔10).
  - Go to IDLE.

Reset values: state=INIT, current_player=01, game_over=0, winner=00, move_ready=0, move_rejected=0, brd_enable=0, brd_write=0. All counters are 0.

## Timing
- Acceptance happens on the handshake cycle; move_col is sampled then.
- Latency from acceptance to the write is 1+(landing row+1) cycles (SCAN) plus 1 cycle.
- CHECK takes at most 4·2·(WIN_LEN-1)=24 cycles.
- move_ready returns high the cycle after FINISH.
- move_ready=0 in every state except IDLE. A move_valid held during busy states is neither accepted nor rejected.
- brd_write is high only in WRITE, for exactly one cycle per accepted move.
- rst_n low on any edge, mid-move included, returns to INIT next cycle with all outputs at reset values. The partial move is discarded.
- Only one board access is issued per cycle.

## Structure
- Shared package (connect_four_pkg): ROWS, COLS, piece codes EMPTY=00, P1=01, P2=10, the state enum, and the direction delta constants.
- One sub-module, connect_four_line_walker: holds the CHECK direction/sign/step/run counters and the bounds logic. Outputs the probe address, probe_valid, and done/win.

## Test plan
- Reset, then count cycles: move_ready rises exactly CLEAR_CYCLES+1 cycles after rst_n goes high; all outputs stay at reset values until then.
- Drop in col 3 on an empty board: one brd_write at (0,3) with data 01; current_player becomes 10; move_ready returns.
- Fill col 0 with 8 alternating drops, then request col 0 a ninth time: move_rejected pulses once, no write occurs, current_player is unchanged.
- Play P1 at cols 0,1,2,3 with P2 at 0,1,2 in between: after the 7th move game_over=1, winner=01, and later move_valid gives move_rejected.
- Build a P2 anti-diagonal whose final piece is placed in the middle of the line: winner=10. This checks that the two-sided run count is summed.
- Assert rst_n low during CHECK: next cycle state is INIT and game_over=0; no stray write occurs.

Source files
------------

// File: rtl/connect_four_pkg.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_pkg
// Description : Board geometry, piece codes, controller states and the line
//               direction deltas shared by the Connect Four move sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package connect_four_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_P1    = 2'b01;
    localparam logic [1:0] c_P2    = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // Row/column step per direction: horizontal, vertical, diagonal, anti-diagonal
    localparam logic signed [1:0] c_DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
    localparam logic signed [1:0] c_DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == c_P1) ? c_P2 : c_P1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/connect_four_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_move_ctrl_if
// Description : Move request handshake plus board storage access bus.
//               slave  = move controller side, master = player/board side.
// Revision    : 1.0 - initial release
// ============================================================================
interface connect_four_move_ctrl_if;

    logic       move_valid;
    logic [2:0] move_col;
    logic       move_ready;
    logic       move_rejected;

    logic       brd_enable;
    logic [2:0] brd_row;
    logic [2:0] brd_col;
    logic [1:0] brd_data_in;
    logic       brd_write;
    logic       brd_drop_allowed;
    logic [1:0] brd_data_out;

    modport master (
        output move_valid, move_col, brd_drop_allowed, brd_data_out,
        input  move_ready, move_rejected, brd_enable, brd_row, brd_col,
               brd_data_in, brd_write
    );

    modport slave (
        input  move_valid, move_col, brd_drop_allowed, brd_data_out,
        output move_ready, move_rejected, brd_enable, brd_row, brd_col,
               brd_data_in, brd_write
    );

endinterface
`default_nettype wire

// File: rtl/connect_four_line_walker.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_line_walker
// Description : Walks the four line directions through the last placed piece,
//               one probe per cycle, counting same-colour neighbours on both
//               sides of the piece and flagging a win.
// Revision    : 1.0 - initial release
// ============================================================================
module connect_four_line_walker
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [1:0] player,
    input  logic [1:0] rd_data,
    output logic [2:0] probe_row,
    output logic [2:0] probe_col,
    output logic       probe_valid,
    output logic       done,
    output logic       win
);
    import connect_four_pkg::*;

    localparam logic [3:0] c_LAST_K = 4'(WIN_LEN - 1);

    logic [1:0] r_dir;
    logic       r_neg;
    logic [3:0] r_k;
    logic [3:0] r_run;

    logic signed [4:0] w_pr;
    logic signed [4:0] w_pc;
    logic              w_match;
    logic              w_side_end;
    logic [3:0]        w_run_nx;

    // Signed displacement k*d, negated while walking the minus side
    function automatic logic signed [4:0] offset(input logic signed [1:0] d,
                                                 input logic [3:0] k,
                                                 input logic neg);
        logic signed [4:0] v;
        if (d == 2'sd0)
            v = 5'sd0;
        else if (d > 2'sd0)
            v = signed'({1'b0, k});
        else
            v = -signed'({1'b0, k});
        return neg ? -v : v;
    endfunction

    // Probe address, bounds test and side/direction termination
    always_comb begin
        w_pr        = signed'({2'b00, row}) + offset(c_DIR_DR[r_dir], r_k, r_neg);
        w_pc        = signed'({2'b00, col}) + offset(c_DIR_DC[r_dir], r_k, r_neg);
        probe_valid = !w_pr[4] && (w_pr[3:0] < 4'(ROWS)) &&
                      !w_pc[4] && (w_pc[3:0] < 4'(COLS));
        probe_row   = w_pr[2:0];
        probe_col   = w_pc[2:0];
        w_match     = probe_valid && (rd_data == player);
        w_run_nx    = w_match ? (r_run + 4'd1) : r_run;
        w_side_end  = !w_match || (r_k == c_LAST_K);
        win         = step && w_side_end && r_neg && (w_run_nx >= c_LAST_K);
        done        = step && w_side_end && r_neg && (win || (r_dir == 2'd3));
    end

    // Direction / side / step / run counters
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            r_dir <= 2'd0;
            r_neg <= 1'b0;
            r_k   <= 4'd1;
            r_run <= 4'd0;
        end else if (step) begin
            if (!w_side_end) begin
                r_k   <= r_k + 4'd1;
                r_run <= w_run_nx;
            end else if (!r_neg) begin
                r_neg <= 1'b1;
                r_k   <= 4'd1;
                r_run <= w_run_nx;
            end else begin
                r_neg <= 1'b0;
                r_k   <= 4'd1;
                r_run <= 4'd0;
                r_dir <= r_dir + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/connect_four_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_move_ctrl
// Description : Accepts column-drop requests, finds the landing row, writes
//               the mover's piece, checks for a line win and tracks turn,
//               draw and game-over status.
// Revision    : 1.0 - initial release
// ============================================================================
module connect_four_move_ctrl
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int WIN_LEN      = 4,
    parameter int CLEAR_CYCLES = 64
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    connect_four_move_ctrl_if.slave bus,
    output logic [1:0]              current_player,
    output logic                    game_over,
    output logic [1:0]              winner
);
    import connect_four_pkg::*;

    localparam int               c_CLR_W    = $clog2(CLEAR_CYCLES + 1);
    localparam logic [c_CLR_W-1:0] c_CLR_DONE = c_CLR_W'(CLEAR_CYCLES);

    state_t             r_state;
    state_t             w_state_nx;
    logic [c_CLR_W-1:0] r_clr_cnt;
    logic [2:0]         r_col;
    logic [2:0]         r_row;
    logic [3:0]         r_scan;
    logic [6:0]         r_pieces;
    logic [1:0]         r_player;
    logic               r_game_over;
    logic [1:0]         r_winner;
    logic               r_win;

    logic               w_accept;
    logic               w_land;
    logic               w_walk_start;
    logic               w_walk_step;
    logic [2:0]         w_probe_row;
    logic [2:0]         w_probe_col;
    logic               w_probe_valid;
    logic               w_walk_done;
    logic               w_walk_win;

    connect_four_line_walker #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_walker (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_walk_start),
        .step        (w_walk_step),
        .row         (r_row),
        .col         (r_col),
        .player      (r_player),
        .rd_data     (bus.brd_data_out),
        .probe_row   (w_probe_row),
        .probe_col   (w_probe_col),
        .probe_valid (w_probe_valid),
        .done        (w_walk_done),
        .win         (w_walk_win)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_INIT;
        else
            r_state <= w_state_nx;
    end

    // Next state, handshake and the single board access of each cycle
    always_comb begin
        w_state_nx        = r_state;
        bus.move_ready    = 1'b0;
        bus.move_rejected = 1'b0;
        bus.brd_enable    = 1'b0;
        bus.brd_row       = 3'd0;
        bus.brd_col       = 3'd0;
        bus.brd_data_in   = c_EMPTY;
        bus.brd_write     = 1'b0;
        w_accept          = 1'b0;
        w_land            = 1'b0;
        w_walk_start      = 1'b0;
        w_walk_step       = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_clr_cnt == c_CLR_DONE)
                    w_state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                bus.move_ready = !r_game_over;
                bus.brd_enable = 1'b1;
                bus.brd_col    = bus.move_col;
                if (bus.move_valid) begin
                    if (r_game_over || !bus.brd_drop_allowed) begin
                        bus.move_rejected = 1'b1;
                    end else begin
                        w_accept   = 1'b1;
                        w_state_nx = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                bus.brd_enable = 1'b1;
                bus.brd_row    = r_scan[2:0];
                bus.brd_col    = r_col;
                if (bus.brd_data_out == c_EMPTY) begin
                    w_land     = 1'b1;
                    w_state_nx = ST_WRITE;
                end else if (r_scan == 4'(ROWS - 1)) begin
                    // Column turned out full despite drop_allowed
                    bus.move_rejected = 1'b1;
                    w_state_nx        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                bus.brd_enable  = 1'b1;
                bus.brd_write   = 1'b1;
                bus.brd_row     = r_row;
                bus.brd_col     = r_col;
                bus.brd_data_in = r_player;
                w_walk_start    = 1'b1;
                w_state_nx      = ST_CHECK;
            end
            ST_CHECK: begin
                w_walk_step = 1'b1;
                if (w_probe_valid) begin
                    bus.brd_enable = 1'b1;
                    bus.brd_row    = w_probe_row;
                    bus.brd_col    = w_probe_col;
                end
                if (w_walk_done)
                    w_state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_INIT;
            end
        endcase
    end

    // Move datapath, piece count and game status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_col       <= 3'd0;
            r_row       <= 3'd0;
            r_scan      <= 4'd0;
            r_pieces    <= 7'd0;
            r_player    <= c_P1;
            r_game_over <= 1'b0;
            r_winner    <= c_EMPTY;
            r_win       <= 1'b0;
        end else begin
            if (r_state == ST_INIT && r_clr_cnt != c_CLR_DONE)
                r_clr_cnt <= r_clr_cnt + c_CLR_W'(1);
            if (w_accept) begin
                r_col  <= bus.move_col;
                r_scan <= 4'd0;
            end
            if (r_state == ST_SCAN && !w_land)
                r_scan <= r_scan + 4'd1;
            if (w_land)
                r_row <= r_scan[2:0];
            if (r_state == ST_WRITE)
                r_pieces <= r_pieces + 7'd1;
            if (r_state == ST_CHECK && w_walk_done)
                r_win <= w_walk_win;
            if (r_state == ST_FINISH) begin
                if (r_win) begin
                    r_game_over <= 1'b1;
                    r_winner    <= r_player;
                end else if (r_pieces == 7'(ROWS * COLS)) begin
                    r_game_over <= 1'b1;
                    r_winner    <= c_EMPTY;
                end else begin
                    r_player <= other_player(r_player);
                end
            end
        end
    end

    assign current_player = r_player;
    assign game_over      = r_game_over;
    assign winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_connect_four_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect_four_move_ctrl
// Description : Scoreboard bench for connect_four_move_ctrl with a simple
//               board storage model behind the board bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect_four_move_ctrl;
    import connect_four_pkg::*;

    typedef struct packed {
        logic       is_rej;
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] current_player;
    logic       game_over;
    logic [1:0] winner;
    logic       clr_board;
    logic [1:0] board [8][8];

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    int  h_col [7]  = '{0, 0, 1, 1, 2, 2, 3};
    int  h_row [7]  = '{0, 1, 0, 1, 0, 1, 0};
    int  a_col [10] = '{2, 3, 1, 2, 0, 0, 0, 0, 1, 1};
    int  a_row [10] = '{0, 0, 0, 1, 0, 1, 2, 3, 1, 2};

    ev_t e_mid;
    bit  seen_wr;

    connect_four_move_ctrl_if bus();

    connect_four_move_ctrl #(
        .ROWS         (8),
        .COLS         (8),
        .WIN_LEN      (4),
        .CLEAR_CYCLES (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .current_player (current_player),
        .game_over      (game_over),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    // Board storage model: combinational read, write on the clock edge
    assign bus.brd_data_out     = board[bus.brd_row][bus.brd_col];
    assign bus.brd_drop_allowed = (board[7][bus.brd_col] == c_EMPTY);

    always @(posedge clk) begin
        if (clr_board) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    board[r][c] <= c_EMPTY;
        end else if (bus.brd_enable && bus.brd_write) begin
            board[bus.brd_row][bus.brd_col] <= bus.brd_data_in;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every write strobe or reject pulse is matched against the queue
    always @(negedge clk) begin : mon
        ev_t a;
        ev_t e;
        if (bus.brd_write || bus.move_rejected) begin
            a = '0;
            if (bus.brd_write) begin
                a.row  = bus.brd_row;
                a.col  = bus.brd_col;
                a.data = bus.brd_data_in;
            end else begin
                a.is_rej = 1'b1;
            end
            if (exp_q.size() == 0) begin
                check(bus.brd_write ? "unexpected write" : "unexpected reject", int'(a), -1);
            end else begin
                e = exp_q.pop_front();
                check("board event {rej,row,col,data}", int'(a), int'(e));
            end
        end
    end

    task automatic reset_dut();
        int n;
        bit seen;
        bus.move_valid = 1'b0;
        rst_n          = 1'b0;
        clr_board      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        clr_board = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.move_ready) begin
                seen = 1'b1;
            end else if (n == 10) begin
                check("init brd_enable", int'(bus.brd_enable), 0);
                check("init brd_write", int'(bus.brd_write), 0);
                check("init current_player", int'(current_player), int'(c_P1));
                check("init game_over/winner", int'({game_over, winner}), 0);
            end
        end
        check("move_ready latency after reset", n, 65);
    endtask

    task automatic move(input int col, input int exp_row, input logic [1:0] exp_data);
        ev_t e;
        bit  done;
        e = '0;
        if (exp_row < 0) begin
            e.is_rej = 1'b1;
        end else begin
            e.row  = 3'(exp_row);
            e.col  = 3'(col);
            e.data = exp_data;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.move_valid = 1'b1;
        bus.move_col   = 3'(col);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.move_ready || bus.move_rejected) begin
                check("handshake rejected", int'(bus.move_rejected), (exp_row < 0) ? 1 : 0);
                done = 1'b1;
            end
        end
        if (!done)
            check("handshake timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.move_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (bus.move_ready || game_over)
                done = 1'b1;
        end
        if (!done)
            check("move completion timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.move_valid = 1'b0;
        bus.move_col   = 3'd0;
        rst_n          = 1'b0;
        clr_board      = 1'b0;

        // Reset behaviour and first drop on an empty board
        reset_dut();
        move(3, 0, c_P1);
        check("player after first drop", int'(current_player), int'(c_P2));
        check("game_over after first drop", int'(game_over), 0);

        // Fill column 0, then a ninth request must bounce
        for (int i = 0; i < 8; i++)
            move(0, i, (i % 2 == 0) ? c_P2 : c_P1);
        check("player after column fill", int'(current_player), int'(c_P2));
        move(0, -1, c_EMPTY);
        check("player after full-column reject", int'(current_player), int'(c_P2));
        check("game_over after full-column reject", int'(game_over), 0);

        // Horizontal P1 win on row 0
        reset_dut();
        for (int i = 0; i < 7; i++)
            move(h_col[i], h_row[i], (i % 2 == 0) ? c_P1 : c_P2);
        check("horizontal game_over", int'(game_over), 1);
        check("horizontal winner", int'(winner), int'(c_P1));
        move(5, -1, c_EMPTY);
        check("player after game-over reject", int'(current_player), int'(c_P1));

        // P2 anti-diagonal closed from the middle
        reset_dut();
        for (int i = 0; i < 10; i++)
            move(a_col[i], a_row[i], (i % 2 == 0) ? c_P1 : c_P2);
        check("anti-diagonal game_over", int'(game_over), 1);
        check("anti-diagonal winner", int'(winner), int'(c_P2));

        // Reset asserted while the line walk is running
        reset_dut();
        move(4, 0, c_P1);
        e_mid      = '0;
        e_mid.row  = 3'd1;
        e_mid.col  = 3'd4;
        e_mid.data = c_P2;
        exp_q.push_back(e_mid);
        @(posedge clk);
        #1;
        bus.move_valid = 1'b1;
        bus.move_col   = 3'd4;
        @(negedge clk);
        check("accept before mid-check reset", int'(bus.move_ready), 1);
        @(posedge clk);
        #1;
        bus.move_valid = 1'b0;
        seen_wr = 1'b0;
        for (int i = 0; i < 20 && !seen_wr; i++) begin
            @(negedge clk);
            if (bus.brd_write)
                seen_wr = 1'b1;
        end
        check("write before mid-check reset", int'(seen_wr), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid-check reset brd_enable", int'(bus.brd_enable), 0);
        check("mid-check reset move_ready", int'(bus.move_ready), 0);
        check("mid-check reset current_player", int'(current_player), int'(c_P1));
        check("mid-check reset game_over", int'(game_over), 0);
        repeat (3) @(posedge clk);
        reset_dut();

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
